// File: rtl/lpc_uart_tx_if.sv
// Write-side and status bundle of the LPC-to-UART transmit path.
// The bridge decoder is the master; the transmitter is the slave.
interface lpc_uart_tx_if #(
  parameter int DEPTH = 16,
  parameter int LVL_W = $clog2(DEPTH + 1)
);
  logic             wr_en;
  logic [7:0]       wr_data;
  logic             ovr_clr;
  logic             full;
  logic             empty;
  logic [LVL_W-1:0] level;
  logic             busy;
  logic             ovr;
  logic             uart_tx;

  modport master (
    output wr_en, wr_data, ovr_clr,
    input  full, empty, level, busy, ovr, uart_tx
  );

  modport slave (
    input  wr_en, wr_data, ovr_clr,
    output full, empty, level, busy, ovr, uart_tx
  );
endinterface

// File: rtl/lpc_uart_tx.sv
// 8N1 UART transmitter fed by a write FIFO.
// Frames are serialised from a private shift register, LSB first.
module lpc_uart_tx #(
  parameter int CLKS_PER_BIT = 286,
  parameter int DEPTH        = 16,
  parameter int LVL_W        = $clog2(DEPTH + 1)
) (
  input logic          lpc_clk,
  input logic          rst,
  lpc_uart_tx_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] T_LAST = TW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE, START, DATA, STOP
  } state_t;

  state_t           state;
  logic [7:0]       mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic [LVL_W-1:0] cnt;
  logic [TW-1:0]    timer;
  logic [2:0]       idx;
  logic [7:0]       shift;
  logic             tx_q, busy_q, ovr_q;
  logic             wr_ok, pop, tick;

  assign bus.full    = (cnt == LVL_W'(DEPTH));
  assign bus.empty   = (cnt == '0);
  assign bus.level   = cnt;
  assign bus.uart_tx = tx_q;
  assign bus.busy    = busy_q;
  assign bus.ovr     = ovr_q;

  assign wr_ok = bus.wr_en && !bus.full;
  assign tick  = (timer == T_LAST);
  // The only pop is the FSM loading a new frame
  assign pop   = !bus.empty &&
                 ((state == IDLE) || (state == STOP && tick));

  // FIFO storage; contents need no reset
  always_ff @(posedge lpc_clk) begin
    if (!rst && wr_ok) mem[wp] <= bus.wr_data;
  end

  // FIFO pointers and occupancy count
  always_ff @(posedge lpc_clk) begin
    if (rst) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr_ok) wp <= wp + 1'b1;
      if (pop)   rp <= rp + 1'b1;
      if (wr_ok && !pop)      cnt <= cnt + 1'b1;
      else if (!wr_ok && pop) cnt <= cnt - 1'b1;
    end
  end

  // Sticky overrun; a new drop beats a same-cycle clear
  always_ff @(posedge lpc_clk) begin
    if (rst)                         ovr_q <= 1'b0;
    else if (bus.wr_en && bus.full)  ovr_q <= 1'b1;
    else if (bus.ovr_clr)            ovr_q <= 1'b0;
  end

  // Frame sequencer with registered line and busy outputs
  always_ff @(posedge lpc_clk) begin
    if (rst) begin
      state  <= IDLE;
      timer  <= '0;
      idx    <= '0;
      shift  <= '0;
      tx_q   <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          tx_q <= 1'b1;
          if (pop) begin
            shift  <= mem[rp];
            timer  <= '0;
            state  <= START;
            tx_q   <= 1'b0;
            busy_q <= 1'b1;
          end
        end
        START: begin
          if (tick) begin
            timer <= '0;
            idx   <= '0;
            state <= DATA;
            tx_q  <= shift[0];
          end else begin
            timer <= timer + 1'b1;
          end
        end
        DATA: begin
          if (tick) begin
            timer <= '0;
            if (idx == 3'd7) begin
              state <= STOP;
              tx_q  <= 1'b1;
            end else begin
              shift <= shift >> 1;
              tx_q  <= shift[1];
              idx   <= idx + 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        STOP: begin
          if (tick) begin
            timer <= '0;
            if (pop) begin
              shift <= mem[rp];
              state <= START;
              tx_q  <= 1'b0;
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lpc_uart_tx.sv
// Bench for lpc_uart_tx: vector table, per-cycle frame check,
// and a serial receiver feeding a byte scoreboard.
module tb_lpc_uart_tx;
  localparam int CPB   = 16;
  localparam int DEPTH = 16;
  localparam int LVL_W = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   frames = 0;
  bit   mon_ign = 1'b0;
  logic [7:0] sb [$];
  int   starts [$];

  lpc_uart_tx_if #(.DEPTH(DEPTH)) bus ();

  lpc_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DEPTH(DEPTH)
  ) dut (
    .lpc_clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         wr_en;
    logic [7:0] data;
    bit         clr;
    int         lvl;
    bit         emp;
    bit         ful;
    bit         bsy;
    bit         tx;
    bit         ov;
  } vec_t;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(logic [7:0] d, bit accept);
    bus.wr_en   = 1'b1;
    bus.wr_data = d;
    if (accept) sb.push_back(d);
    tick();
    bus.wr_en = 1'b0;
  endtask

  task automatic drain(int max);
    int n = 0;
    while ((sb.size() != 0 || bus.busy) && n < max) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'(n < max), 32'd1);
  endtask

  // Serial receiver: mid-bit sampling, compares against the scoreboard
  always begin
    @(negedge clk);
    if (bus.uart_tx === 1'b0) begin
      logic [7:0] b;
      logic       stp;
      int         st;
      st = cyc;
      repeat (CPB / 2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(negedge clk);
        b[i] = bus.uart_tx;
      end
      repeat (CPB) @(negedge clk);
      stp = bus.uart_tx;
      if (!mon_ign) begin
        frames++;
        starts.push_back(st);
        chk("rx_stop", 32'(stp), 32'd1);
        if (sb.size() == 0) begin
          chk("rx_unexpected", 32'(b), 32'hffff_ffff);
        end else begin
          chk("rx_byte", 32'(b), 32'(sb.pop_front()));
        end
      end
    end
  end

  initial begin
    vec_t vt [4];
    logic [7:0] fb;
    bit exp_bit;
    int bad;

    rst = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    bus.ovr_clr = 1'b0;
    tick();
    rst = 1'b0;
    chk("rst_tx", 32'(bus.uart_tx), 32'd1);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ovr", 32'(bus.ovr), 32'd0);
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_full", 32'(bus.full), 32'd0);

    bad = 0;
    repeat (10) begin
      tick();
      if (bus.uart_tx !== 1'b1 || bus.empty !== 1'b1 ||
          bus.level !== '0 || bus.busy !== 1'b0) bad++;
    end
    chk("idle_10", 32'(bad), 32'd0);

    // 0x0f: exact per-cycle frame shape and latency
    fb = 8'h0f;
    wr(fb, 1'b1);
    chk("lat_n_tx", 32'(bus.uart_tx), 32'd1);
    chk("lat_n_busy", 32'(bus.busy), 32'd0);
    tick();
    bad = 0;
    for (int b = 0; b < 10; b++) begin
      exp_bit = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : fb[b-1];
      for (int c = 0; c < CPB; c++) begin
        if (bus.uart_tx !== exp_bit || bus.busy !== 1'b1) bad++;
        tick();
      end
    end
    chk("f0f_shape", 32'(bad), 32'd0);
    chk("f0f_busy_end", 32'(bus.busy), 32'd0);
    chk("f0f_tx_end", 32'(bus.uart_tx), 32'd1);
    drain(20 * CPB);

    // 0xa5 then 0xf1 back to back, driven from a vector table
    vt[0] = '{1'b1, 8'ha5, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[1] = '{1'b1, 8'hf1, 1'b0, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[2] = '{1'b0, 8'h00, 1'b0, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[3] = '{1'b0, 8'h00, 1'b1, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    starts.delete();
    for (int i = 0; i < 4; i++) begin
      bus.wr_en   = vt[i].wr_en;
      bus.wr_data = vt[i].data;
      bus.ovr_clr = vt[i].clr;
      if (vt[i].wr_en) sb.push_back(vt[i].data);
      tick();
      bus.wr_en   = 1'b0;
      bus.ovr_clr = 1'b0;
      chk($sformatf("vec%0d_lvl", i), 32'(bus.level), 32'(vt[i].lvl));
      chk($sformatf("vec%0d_emp", i), 32'(bus.empty), 32'(vt[i].emp));
      chk($sformatf("vec%0d_ful", i), 32'(bus.full), 32'(vt[i].ful));
      chk($sformatf("vec%0d_bsy", i), 32'(bus.busy), 32'(vt[i].bsy));
      chk($sformatf("vec%0d_tx", i), 32'(bus.uart_tx), 32'(vt[i].tx));
      chk($sformatf("vec%0d_ovr", i), 32'(bus.ovr), 32'(vt[i].ov));
    end
    repeat (10 * CPB - 3) tick();
    chk("b2b_pre_lvl", 32'(bus.level), 32'd1);
    chk("b2b_pre_tx", 32'(bus.uart_tx), 32'd1);
    tick();
    chk("b2b_post_lvl", 32'(bus.level), 32'd0);
    chk("b2b_post_tx", 32'(bus.uart_tx), 32'd0);
    chk("b2b_post_busy", 32'(bus.busy), 32'd1);
    drain(30 * CPB);
    chk("b2b_frames", 32'(starts.size()), 32'd2);
    if (starts.size() == 2)
      chk("b2b_gap", 32'(starts[1] - starts[0]), 32'(10 * CPB));

    // 17 writes from idle: first pop frees a slot in time
    frames = 0;
    for (int i = 0; i < 17; i++) wr(8'(8'hf0 + i), 1'b1);
    chk("w17_ovr", 32'(bus.ovr), 32'd0);
    chk("w17_full", 32'(bus.full), 32'd1);
    chk("w17_lvl", 32'(bus.level), 32'(DEPTH));
    drain(20 * 10 * CPB);
    chk("w17_frames", 32'(frames), 32'd17);

    // 18 writes: the last one is dropped and flags overrun
    frames = 0;
    for (int i = 0; i < 18; i++) wr(8'(8'hf0 + i), i < 17);
    chk("w18_ovr", 32'(bus.ovr), 32'd1);
    chk("w18_lvl", 32'(bus.level), 32'(DEPTH));
    bus.ovr_clr = 1'b1;
    tick();
    bus.ovr_clr = 1'b0;
    chk("clr_ovr", 32'(bus.ovr), 32'd0);
    bus.ovr_clr = 1'b1;
    wr(8'h55, 1'b0);
    bus.ovr_clr = 1'b0;
    chk("clr_vs_set", 32'(bus.ovr), 32'd1);
    bus.ovr_clr = 1'b1;
    tick();
    bus.ovr_clr = 1'b0;
    chk("clr_again", 32'(bus.ovr), 32'd0);
    drain(20 * 10 * CPB);
    chk("w18_frames", 32'(frames), 32'd17);

    // Reset in mid-DATA with bytes still queued
    repeat (2 * CPB) tick();
    mon_ign = 1'b1;
    sb.delete();
    wr(8'hf3, 1'b0);
    wr(8'h11, 1'b0);
    wr(8'h22, 1'b0);
    wr(8'h33, 1'b0);
    repeat (3 * CPB) tick();
    chk("pre_rst_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_tx", 32'(bus.uart_tx), 32'd1);
    chk("mid_rst_lvl", 32'(bus.level), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_empty", 32'(bus.empty), 32'd1);
    bad = 0;
    repeat (12 * CPB) begin
      tick();
      if (bus.uart_tx !== 1'b1 || bus.busy !== 1'b0) bad++;
    end
    chk("post_rst_quiet", 32'(bad), 32'd0);
    mon_ign = 1'b0;

    // Loopback of 0xf4..0xfa through the serial receiver
    frames = 0;
    for (int i = 0; i < 7; i++) wr(8'(8'hf4 + i), 1'b1);
    drain(10 * 10 * CPB);
    chk("loop_frames", 32'(frames), 32'd7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
